// File: rtl/mem_store_checker.sv
// mem_store_checker
//   Snoops the CPU data-memory write port and checks the stores against a
//   programmable, ordered table of up to DEPTH expected (address, data)
//   pairs. Reports a sticky pass/fail verdict, an error code and the store
//   that caused a failure.
//
//   Optional feature: define MEM_STORE_CHECKER_TIMEOUT_EN to build an idle
//   counter that fails the run (err_code = 3) after TIMEOUT RUN cycles
//   without a matched store.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   cfg_we/idx/addr/data  table entry write (ignored while running)
//   cfg_num             entries to check, captured on start (clamped to DEPTH)
//   start               single-cycle arm pulse (ignored while running)
//   memwrite/dataaddr/writedata  snooped store port
//   done, pass, fail    verdict flags (pass/fail sticky until next start)
//   err_code            0 none, 1 unexpected address, 2 data mismatch, 3 timeout
//   match_cnt           expected stores matched so far
//   fail_addr/fail_data store captured on entering FAIL
module mem_store_checker #(
    parameter int          DW          = 32,
    parameter int          AW          = 32,
    parameter int          DEPTH       = 4,
    parameter int          STRICT      = 0,
    parameter int unsigned IGNORE_ADDR = 80,
    parameter int          TIMEOUT     = 1024,
    localparam int         IW          = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int         NW          = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_idx,
    input  logic [AW-1:0] cfg_addr,
    input  logic [DW-1:0] cfg_data,
    input  logic [NW-1:0] cfg_num,
    input  logic          start,
    input  logic          memwrite,
    input  logic [AW-1:0] dataaddr,
    input  logic [DW-1:0] writedata,
    output logic          done,
    output logic          pass,
    output logic          fail,
    output logic [1:0]    err_code,
    output logic [NW-1:0] match_cnt,
    output logic [AW-1:0] fail_addr,
    output logic [DW-1:0] fail_data
);

    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_e;

    localparam logic [AW-1:0] IGN     = AW'(IGNORE_ADDR);
    localparam logic [NW-1:0] DEPTH_N = NW'(DEPTH);
    localparam logic [IW:0]   DEPTH_I = (IW + 1)'(DEPTH);

    state_e        state_q, state_d;
    logic [AW-1:0] tab_addr_q [DEPTH];
    logic [DW-1:0] tab_data_q [DEPTH];
    logic [NW-1:0] num_q, num_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [NW-1:0] match_cnt_q, match_cnt_d;
    logic          pass_q, pass_d;
    logic          fail_q, fail_d;
    logic          done_q, done_d;
    logic [1:0]    err_q, err_d;
    logic [AW-1:0] fail_addr_q, fail_addr_d;
    logic [DW-1:0] fail_data_q, fail_data_d;

`ifdef MEM_STORE_CHECKER_TIMEOUT_EN
    localparam int          TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    logic          cfg_ok;
    logic          st_chk;
    logic          addr_hit;
    logic          data_hit;
    logic [NW-1:0] num_clamp;

    // Table is frozen while a run is in progress.
    assign cfg_ok    = cfg_we && (state_q != RUN) && ({1'b0, cfg_idx} < DEPTH_I);
    // Stores to the ignore address never take part in checking, even if a
    // table entry holds the same address.
    assign st_chk    = memwrite && (dataaddr != IGN);
    assign addr_hit  = (dataaddr == tab_addr_q[ptr_q]);
    assign data_hit  = (writedata == tab_data_q[ptr_q]);
    assign num_clamp = (cfg_num > DEPTH_N) ? DEPTH_N : cfg_num;

    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        ptr_d       = ptr_q;
        match_cnt_d = match_cnt_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        err_d       = err_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
`ifdef MEM_STORE_CHECKER_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif
        if (state_q == RUN) begin
`ifdef MEM_STORE_CHECKER_TIMEOUT_EN
            tmo_d = tmo_q + 1'b1;
`endif
            if (st_chk && addr_hit && data_hit) begin
                ptr_d       = ptr_q + 1'b1;
                match_cnt_d = match_cnt_q + 1'b1;
`ifdef MEM_STORE_CHECKER_TIMEOUT_EN
                tmo_d       = '0;
`endif
                // match_cnt tracks ptr, so this is the last-entry test.
                if (match_cnt_d == num_q) begin
                    state_d = PASS;
                    pass_d  = 1'b1;
                end
            end else if (st_chk && (addr_hit || (STRICT != 0))) begin
                state_d     = FAIL;
                fail_d      = 1'b1;
                err_d       = addr_hit ? 2'd2 : 2'd1;
                fail_addr_d = dataaddr;
                fail_data_d = writedata;
            end
`ifdef MEM_STORE_CHECKER_TIMEOUT_EN
            else if (tmo_q == TMO_MAX) begin
                state_d     = FAIL;
                fail_d      = 1'b1;
                err_d       = 2'd3;
                fail_addr_d = '0;
                fail_data_d = '0;
            end
`endif
        end else if (start) begin
            ptr_d       = '0;
            match_cnt_d = '0;
            fail_d      = 1'b0;
            err_d       = 2'd0;
            num_d       = num_clamp;
`ifdef MEM_STORE_CHECKER_TIMEOUT_EN
            tmo_d       = '0;
`endif
            if (num_clamp == '0) begin
                state_d = PASS;
                pass_d  = 1'b1;
            end else begin
                state_d = RUN;
                pass_d  = 1'b0;
            end
        end
    end

    assign done_d = pass_d | fail_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            num_q       <= '0;
            ptr_q       <= '0;
            match_cnt_q <= '0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 2'd0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
`ifdef MEM_STORE_CHECKER_TIMEOUT_EN
            tmo_q       <= '0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                tab_addr_q[i] <= '0;
                tab_data_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            ptr_q       <= ptr_d;
            match_cnt_q <= match_cnt_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            done_q      <= done_d;
            err_q       <= err_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
`ifdef MEM_STORE_CHECKER_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
            if (cfg_ok) begin
                tab_addr_q[cfg_idx] <= cfg_addr;
                tab_data_q[cfg_idx] <= cfg_data;
            end
        end
    end

    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign err_code  = err_q;
    assign match_cnt = match_cnt_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;

endmodule

// File: tb/tb_mem_store_checker.sv
// Bench for mem_store_checker: a lax (STRICT=0) and a strict (STRICT=1)
// instance share one stimulus stream. Expected verdicts are queued per
// instance when a deciding store is issued; a negedge monitor pops and
// compares on every rising edge of done.
module tb_mem_store_checker;
    localparam int NW = 3;
    localparam int IW = 2;

    typedef struct {
        int            cyc;
        logic          pass;
        logic          fail;
        logic [1:0]    err;
        logic [NW-1:0] mc;
        logic [31:0]   fa;
        logic [31:0]   fd;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_we = 1'b0;
    logic [IW-1:0] cfg_idx = '0;
    logic [31:0]   cfg_addr = '0;
    logic [31:0]   cfg_data = '0;
    logic [NW-1:0] cfg_num = '0;
    logic          start = 1'b0;
    logic          memwrite = 1'b0;
    logic [31:0]   dataaddr = '0;
    logic [31:0]   writedata = '0;

    logic l_done, l_pass, l_fail, s_done, s_pass, s_fail;
    logic [1:0] l_err, s_err;
    logic [NW-1:0] l_mc, s_mc;
    logic [31:0] l_fa, l_fd, s_fa, s_fd;

    always #5 clk = ~clk;

    mem_store_checker #(.DW(32), .AW(32), .DEPTH(4), .STRICT(0), .IGNORE_ADDR(80), .TIMEOUT(16)) u_lax (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_num(cfg_num), .start(start), .memwrite(memwrite),
        .dataaddr(dataaddr), .writedata(writedata), .done(l_done), .pass(l_pass),
        .fail(l_fail), .err_code(l_err), .match_cnt(l_mc), .fail_addr(l_fa), .fail_data(l_fd)
    );

    mem_store_checker #(.DW(32), .AW(32), .DEPTH(4), .STRICT(1), .IGNORE_ADDR(80), .TIMEOUT(16)) u_strict (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_num(cfg_num), .start(start), .memwrite(memwrite),
        .dataaddr(dataaddr), .writedata(writedata), .done(s_done), .pass(s_pass),
        .fail(s_fail), .err_code(s_err), .match_cnt(s_mc), .fail_addr(s_fa), .fail_data(s_fd)
    );

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q_l[$];
    exp_t q_s[$];
    logic l_prev = 1'b0;
    logic s_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cmp_verdict(input string who, input exp_t e, input logic p, input logic f,
                               input logic [1:0] err, input logic [NW-1:0] mc,
                               input logic [31:0] fa, input logic [31:0] fd);
        chk({who, " verdict cycle"}, 64'(cyc), 64'(e.cyc));
        chk({who, " pass"}, 64'(p), 64'(e.pass));
        chk({who, " fail"}, 64'(f), 64'(e.fail));
        chk({who, " err_code"}, 64'(err), 64'(e.err));
        chk({who, " match_cnt"}, 64'(mc), 64'(e.mc));
        if (e.fail) begin
            chk({who, " fail_addr"}, 64'(fa), 64'(e.fa));
            chk({who, " fail_data"}, 64'(fd), 64'(e.fd));
        end
    endtask

    always @(negedge clk) begin
        if (l_done && !l_prev) begin
            if (q_l.size() == 0) chk("lax spurious verdict", 64'd1, 64'd0);
            else cmp_verdict("lax", q_l.pop_front(), l_pass, l_fail, l_err, l_mc, l_fa, l_fd);
        end
        if (s_done && !s_prev) begin
            if (q_s.size() == 0) chk("strict spurious verdict", 64'd1, 64'd0);
            else cmp_verdict("strict", q_s.pop_front(), s_pass, s_fail, s_err, s_mc, s_fa, s_fd);
        end
        l_prev <= l_done;
        s_prev <= s_done;
    end

    // Expected verdict for a decision sampled at the next rising edge.
    function automatic exp_t ep(input int mc);
        exp_t e;
        e.cyc = cyc + 1; e.pass = 1'b1; e.fail = 1'b0; e.err = 2'd0;
        e.mc = mc[NW-1:0]; e.fa = '0; e.fd = '0;
        return e;
    endfunction

    function automatic exp_t ef(input int err, input int mc, input logic [31:0] fa, input logic [31:0] fd);
        exp_t e;
        e.cyc = cyc + 1; e.pass = 1'b0; e.fail = 1'b1; e.err = err[1:0];
        e.mc = mc[NW-1:0]; e.fa = fa; e.fd = fd;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input int idx, input logic [31:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_idx = idx[IW-1:0]; cfg_addr = a; cfg_data = d;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic arm(input int n);
        start = 1'b1; cfg_num = n[NW-1:0];
        step();
        start = 1'b0;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1'b1; dataaddr = a; writedata = d;
        step();
        memwrite = 1'b0;
    endtask

    task automatic both(input exp_t e);
        q_l.push_back(e);
        q_s.push_back(e);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " lax flags"}, 64'({l_done, l_pass, l_fail, l_err, l_mc}), 64'd0);
        chk({tag, " lax fail store"}, {l_fa, l_fd}, 64'd0);
        chk({tag, " strict flags"}, 64'({s_done, s_pass, s_fail, s_err, s_mc}), 64'd0);
        chk({tag, " strict fail store"}, {s_fa, s_fd}, 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(); step();
        rst = 1'b1;
    endtask

    initial begin
        do_reset();
        chk_zero("reset");

        // Single-entry pass; store to the ignore address is skipped.
        prog(0, 32'd84, 32'd7);
        arm(1);
        st(32'd80, 32'd5);
        both(ep(1));
        st(32'd84, 32'd7);

        // Data mismatch at the expected address.
        arm(1);
        both(ef(2, 0, 32'd84, 32'd6));
        st(32'd84, 32'd6);

        // Unexpected address: ignored when lax, fatal when strict.
        arm(1);
        q_s.push_back(ef(1, 0, 32'd88, 32'd1));
        st(32'd88, 32'd1);
        q_l.push_back(ep(1));
        st(32'd84, 32'd7);

        // Ordered back-to-back sequence.
        prog(0, 32'h10, 32'd1);
        prog(1, 32'h14, 32'd2);
        prog(2, 32'h18, 32'd3);
        arm(3);
        st(32'h10, 32'd1);
        st(32'h14, 32'd2);
        both(ep(3));
        st(32'h18, 32'd3);

        // Last two swapped: strict fails, lax skips the early store.
        arm(3);
        st(32'h10, 32'd1);
        q_s.push_back(ef(1, 1, 32'h18, 32'd3));
        st(32'h18, 32'd3);
        st(32'h14, 32'd2);
        q_l.push_back(ep(3));
        st(32'h18, 32'd3);

        // cfg_num clamped to DEPTH; table write during RUN is dropped.
        prog(3, 32'h1C, 32'd4);
        arm(7);
        prog(0, 32'h20, 32'd9);
        st(32'h10, 32'd1);
        st(32'h14, 32'd2);
        st(32'h18, 32'd3);
        both(ep(4));
        st(32'h1C, 32'd4);

        // Table write, start and a store in one cycle: write is used, store is not checked.
        prog(0, 32'h40, 32'd1);
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_addr = 32'd84; cfg_data = 32'd7;
        start = 1'b1; cfg_num = 3'd1;
        memwrite = 1'b1; dataaddr = 32'd84; writedata = 32'd7;
        step();
        cfg_we = 1'b0; start = 1'b0; memwrite = 1'b0;
        both(ep(1));
        st(32'd84, 32'd7);

        // Reset in RUN after one of three matches.
        prog(0, 32'h10, 32'd1);
        prog(1, 32'h14, 32'd2);
        prog(2, 32'h18, 32'd3);
        arm(3);
        st(32'h10, 32'd1);
        chk("lax match_cnt mid-run", 64'(l_mc), 64'd1);
        chk("strict match_cnt mid-run", 64'(s_mc), 64'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk_zero("mid-run reset");

        // cfg_num = 0 passes immediately.
        both(ep(0));
        arm(0);

        // Reset cleared the table: entry 0 is (0, 0).
        arm(1);
        both(ep(1));
        st(32'd0, 32'd0);

        // Fail, then restart from FAIL clears the verdict.
        prog(0, 32'd84, 32'd7);
        arm(1);
        both(ef(2, 0, 32'd84, 32'd6));
        st(32'd84, 32'd6);
        arm(1);
        chk("lax restart fail/err", 64'({l_fail, l_err}), 64'd0);
        chk("strict restart fail/err", 64'({s_fail, s_err}), 64'd0);
        both(ep(1));
        st(32'd84, 32'd7);

        // Ignore address beats a matching table entry; start in RUN is ignored.
        prog(0, 32'd80, 32'd5);
        arm(1);
        st(32'd80, 32'd5);
        st(32'd80, 32'd6);
        arm(0);
        step();
        chk("lax ignore still running", 64'({l_done, l_mc}), 64'd0);
        chk("strict ignore still running", 64'({s_done, s_mc}), 64'd0);
        do_reset();

`ifdef MEM_STORE_CHECKER_TIMEOUT_EN
        prog(0, 32'd84, 32'd7);
        begin
            exp_t e;
            e = ef(3, 0, 32'd0, 32'd0);
            e.cyc = cyc + 18;
            both(e);
        end
        arm(1);
        repeat (20) step();
`else
        prog(0, 32'd84, 32'd7);
        arm(1);
        repeat (100) step();
        chk("lax no timeout", 64'(l_done), 64'd0);
        chk("strict no timeout", 64'(s_done), 64'd0);
`endif

        repeat (3) step();
        chk("lax verdicts outstanding", 64'(q_l.size()), 64'd0);
        chk("strict verdicts outstanding", 64'(q_s.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
